// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the primary writeback and a
// FIFO-buffered secondary source. The secondary source cannot be starved, and
// the block exports a pending-write mask.
module rf_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p_valid,
    input  logic [4:0]               p_wa,
    input  logic [31:0]              p_wd,
    output logic                     p_ready,
    input  logic                     s_valid,
    input  logic [4:0]               s_wa,
    input  logic [31:0]              s_wd,
    output logic                     s_ready,
    output logic                     we3,
    output logic [4:0]               wa3,
    output logic [31:0]              wd3,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t           mem_q [DEPTH];
    wr_t           mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    wait_q, wait_d;
    logic          we3_q, we3_d;
    logic [4:0]    wa3_q, wa3_d;
    logic [31:0]   wd3_q, wd3_d;

    logic          force_issue, fifo_ne, p_live, push, pop;
    wr_t           head;
    logic [PW-1:0] idx;

    always_comb begin
        fifo_ne     = (count_q != '0);
        force_issue = (wait_q == 4'(MAX_WAIT)) && fifo_ne;
        p_ready     = !force_issue;
        s_ready     = (count_q != CW'(DEPTH));
        p_live      = p_valid && (p_wa != 5'd0);
        // Register-0 requests complete the handshake but never occupy the port.
        pop         = force_issue || (!p_live && fifo_ne);
        push        = s_valid && s_ready && (s_wa != 5'd0);
        head        = mem_q[rd_ptr_q];

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = '{wa: s_wa, wd: s_wd};
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        if (pop || !fifo_ne)              wait_d = 4'd0;
        else if (wait_q != 4'(MAX_WAIT))  wait_d = wait_q + 4'd1;
        else                              wait_d = wait_q;

        we3_d = pop || p_live;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (pop) begin
            wa3_d = head.wa;
            wd3_d = head.wd;
        end else if (p_live) begin
            wa3_d = p_wa;
            wd3_d = p_wd;
        end
    end

    always_comb begin
        pending = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) pending[mem_q[idx].wa] = 1'b1;
        end
        if (we3_q) pending[wa3_q] = 1'b1;
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
        end
    end

    // Entry storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign we3        = we3_q;
    assign wa3        = wa3_q;
    assign wd3        = wd3_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter. A queue-based reference
// model predicts register-file writes, which a separate monitor checks.
module tb_rf_write_arbiter;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   p_valid = 1'b0, s_valid = 1'b0;
    logic [4:0]             p_wa = '0, s_wa = '0;
    logic [31:0]            p_wd = '0, s_wd = '0;
    logic                   p_ready, s_ready, we3;
    logic [4:0]             wa3;
    logic [31:0]            wd3, pending;
    logic [$clog2(DEPTH):0] fifo_count;

    rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_wa(p_wa), .p_wd(p_wd), .p_ready(p_ready),
        .s_valid(s_valid), .s_wa(s_wa), .s_wd(s_wd), .s_ready(s_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    wr_t        mq[$];
    int         mwait = 0;
    logic       m_we = 1'b0;
    logic [4:0] m_wa = '0;
    logic [31:0] m_wd = '0;
    wr_t        exp_q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] m = '0;
        foreach (mq[i]) m[mq[i].wa] = 1'b1;
        if (m_we) m[m_wa] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // One clock: check registered-state outputs, drive inputs, advance model.
    task automatic cycle(input logic rst, input logic pv, input logic [4:0] pwa,
                         input logic [31:0] pwd, input logic sv,
                         input logic [4:0] swa, input logic [31:0] swd);
        bit   frc, srdy, popped, issued;
        int   sz;
        wr_t  w;
        @(negedge clk);
        frc  = (mwait == MAX_WAIT) && (mq.size() > 0);
        srdy = (mq.size() != DEPTH);
        chk("p_ready", 64'(p_ready), 64'(!frc));
        chk("s_ready", 64'(s_ready), 64'(srdy));
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
        chk("pending", 64'(pending), 64'(model_pending()));
        chk("wa3_wd3", {27'd0, wa3, wd3}, {27'd0, m_wa, m_wd});
        reset = rst; p_valid = pv; p_wa = pwa; p_wd = pwd;
        s_valid = sv; s_wa = swa; s_wd = swd;
        if (rst) begin
            mq.delete(); mwait = 0; m_we = 0; m_wa = '0; m_wd = '0;
            return;
        end
        sz = mq.size(); popped = 0; issued = 1;
        if (frc || (!(pv && pwa != 0) && sz > 0)) begin
            w = mq.pop_front(); popped = 1;
        end else if (pv && pwa != 0) begin
            w = '{wa: pwa, wd: pwd};
        end else begin
            issued = 0;
        end
        if (sv && srdy && swa != 0) mq.push_back('{wa: swa, wd: swd});
        if (popped || sz == 0) mwait = 0;
        else if (mwait < MAX_WAIT) mwait++;
        m_we = issued;
        if (issued) begin
            m_wa = w.wa; m_wd = w.wd;
            exp_q.push_back(w);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // Monitor: each write seen on the port must match the oldest prediction.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (we3 === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual wa=%0d wd=%0h required none", wa3, wd3);
                end else begin
                    e = exp_q.pop_front();
                    if (wa3 !== e.wa || wd3 !== e.wd) begin
                        errors++;
                        $display("FAIL write actual wa=%0d wd=%0h required wa=%0d wd=%0h",
                                 wa3, wd3, e.wa, e.wd);
                    end
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missing_write actual we3=%b required wa=%0d wd=%0h", we3, e.wa, e.wd);
            end
        end
    end

    initial begin
        // Reset with random inputs.
        for (int i = 0; i < 2; i++)
            cycle(1, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
        // Primary only.
        cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        idle(2);
        // Secondary when idle.
        cycle(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h1234);
        idle(3);
        // Starvation: one queued entry against a continuously valid primary.
        cycle(0, 1, 5'd1, 32'hA0, 1, 5'd9, 32'h99);
        for (int i = 0; i < 8; i++) cycle(0, 1, 5'(i + 2), 32'hB0 + i, 0, 5'd0, 32'd0);
        idle(2);
        // Full FIFO: entries 3 and 4, then 9 held while full.
        cycle(0, 1, 5'd20, 32'h1, 1, 5'd3, 32'h33);
        cycle(0, 1, 5'd21, 32'h2, 1, 5'd4, 32'h44);
        for (int i = 0; i < 6; i++) cycle(0, 1, 5'd22, 32'h3 + i, 1, 5'd9, 32'h999);
        for (int i = 0; i < 10; i++) cycle(0, 1, 5'd23, 32'h10 + i, 0, 5'd0, 32'd0);
        idle(3);
        // Register 0 on both sources.
        cycle(0, 1, 5'd0, 32'h5, 1, 5'd0, 32'h6);
        cycle(0, 1, 5'd0, 32'h7, 1, 5'd0, 32'h8);
        idle(2);
        // Reset with two entries queued behind a busy primary.
        cycle(0, 1, 5'd10, 32'hC0, 1, 5'd3, 32'hC3);
        cycle(0, 1, 5'd11, 32'hC1, 1, 5'd4, 32'hC4);
        cycle(1, 1, 5'd12, 32'hC2, 0, 5'd0, 32'd0);
        idle(4);
        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6), 5'($urandom),
                  $urandom, ($urandom_range(0, 9) < 4), 5'($urandom), $urandom);
        idle(DEPTH + 4);
        chk("drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port (we3/wa3/wd3) between two writeback sources. The primary source is the main datapath writeback. The secondary source is a long-latency unit, such as a multiply/divide or load-return path, which is buffered in a small FIFO. The block sits directly in front of the three-ported register file, guarantees the secondary source cannot starve, and exports a pending-write mask for hazard detection.

## Interface
- DEPTH, 2, secondary FIFO entries; power of two, ≥2
- MAX_WAIT, 4, consecutive cycles a non-empty FIFO head may lose arbitration before it is forced; 1..15
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- p_valid  in  1  primary write request
- p_wa  in  5  primary destination register
- p_wd  in  32  primary write data
- p_ready  out  1  primary accepted when p_valid && p_ready
- s_valid  in  1  secondary write request
- s_wa  in  5  secondary destination register
- s_wd  in  32  secondary write data
- s_ready  out  1  secondary accepted into FIFO when s_valid && s_ready
- we3  out  1  register-file write enable, registered
- wa3  out  5  register-file write address, registered
- wd3  out  32  register-file write data, registered
- pending  out  32  bit i set while a write to register i is queued or in the output stage
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- **FIFO acceptance:** s_ready = (fifo_count != DEPTH), based on registered state only. A full FIFO does not accept in the same cycle it pops.
- **Register 0, secondary:** a secondary request with s_wa == 0 is accepted (handshake completes) but not enqueued.
- **Register 0, primary:** a primary request with p_wa == 0 is accepted but issues no write. The port is then treated as free that cycle.
- **Force signal:** force = (wait_cnt == MAX_WAIT) && FIFO non-empty. p_ready = !force.
- **Issue selection, evaluated in this order each cycle:**
  1. force → issue the FIFO head.
  2. Else p_valid with p_wa != 0 → issue primary.
  3. Else FIFO non-empty → issue the FIFO head.
  4. Else no issue.
- **No bypass:** a secondary request never bypasses the FIFO. An entry enqueued in cycle N is issuable at cycle N+1 at the earliest.
- **wait_cnt:**
  - resets to 0;
  - cleared on any FIFO pop or when the FIFO is empty;
  - otherwise increments by 1 when the FIFO is non-empty and the head is not popped, saturating at MAX_WAIT.
- **Output stage:** on issue, the next edge loads we3 = 1, wa3 = issued address, wd3 = issued data. With no issue, we3 = 0 and wa3/wd3 hold their values.
- **pending:** OR of the one-hot decodes of all valid FIFO entries, plus wa3 when we3 = 1. Bit 0 is always 0. The mask is combinational from registered state.
- **Ordering:** FIFO entries retire in order. No ordering is enforced between primary and secondary writes to the same register; the upstream hazard logic uses pending for that.
- **Reset:** we3 = 0, wa3 = 0, wd3 = 0, FIFO emptied (fifo_count = 0), wait_cnt = 0, pending = 0.
- **Reset mid-operation:** all queued writes are discarded and no partial write is issued. s_ready = 1 and p_ready = 1 in the cycle after reset deasserts.

## Timing
- **Primary latency:** accepted at edge N → we3/wa3/wd3 valid during cycle N+1 → register file written at edge N+2.
- **Secondary latency:** minimum 2 cycles from acceptance to we3 (one cycle in the FIFO, one in the output stage).
- **Throughput:** one register-file write per cycle maximum. A simultaneous enqueue and pop on a non-full FIFO leaves fifo_count unchanged.
- **Starvation bound:** a FIFO head waits at most MAX_WAIT cycles. The primary stalls (p_ready = 0) for exactly one cycle per forced issue.
- **Wrap-around:** FIFO pointers wrap modulo DEPTH. fifo_count distinguishes full from empty.
- **Combinational paths:** p_ready, s_ready, pending and fifo_count have no combinational path from any input.

## Test plan
- **Reset and idle:** assert reset 2 cycles with random inputs → we3 = 0, wa3 = 0, wd3 = 0, pending = 0, fifo_count = 0, p_ready = 1, s_ready = 1.
- **Primary only:** p_valid with p_wa = 5, p_wd = 0xDEADBEEF for one cycle → next cycle we3 = 1, wa3 = 5, wd3 = 0xDEADBEEF, pending[5] = 1; the cycle after, we3 = 0.
- **Secondary when idle:** s_wa = 7, s_wd = 0x1234 accepted at edge N → fifo_count = 1 and pending[7] = 1 during cycle N+1; we3 = 1, wa3 = 7 during cycle N+2.
- **Starvation, MAX_WAIT = 4:** primary valid every cycle, one secondary entry queued → the primary is granted 4 cycles, then p_ready = 0 for one cycle and the secondary issues; p_ready = 1 again on the next cycle.
- **Full FIFO, DEPTH = 2:** two secondary entries (wa 3, 4) queued while the primary is continuously valid → s_ready = 0, a third s_valid is not accepted, and a later pop re-raises s_ready; entries retire as 3 then 4.
- **Register 0 and mid-operation reset:** s_wa = 0 and p_wa = 0 requests → handshakes complete, no we3 pulse, pending = 0. Reset asserted with 2 entries queued → the next cycle we3 = 0, fifo_count = 0, and no queued write is ever issued.
